// File: rtl/count_mod.sv
// ============================================================================
// Module      : count_mod
// Description : Up/down counter with prescaler, load, modulo, wrap/saturate,
//               terminal-count pulse and sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_mod #(
  parameter int COUNTER_WIDTH  = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      up,
  input  logic                      sat,
  input  logic                      load,
  input  logic [COUNTER_WIDTH-1:0]  load_val,
  input  logic [COUNTER_WIDTH-1:0]  modulo,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      clr_ovf,
  output logic [COUNTER_WIDTH-1:0]  cnt,
  output logic                      tick,
  output logic                      tc,
  output logic                      ovf
);

  logic [COUNTER_WIDTH-1:0]  r_cnt;
  logic [PRESCALE_WIDTH-1:0] r_pre;
  logic                      r_tick;
  logic                      r_tc;
  logic                      r_ovf;

  logic                      w_step;
  logic                      w_boundary;
  logic [COUNTER_WIDTH-1:0]  w_step_val;
  logic [COUNTER_WIDTH-1:0]  w_load_val;

  assign w_step     = en && !load && (r_pre == prescale);
  assign w_load_val = (load_val > modulo) ? modulo : load_val;

  always_comb begin
    w_boundary = 1'b0;
    w_step_val = r_cnt;
    if (up) begin
      if (r_cnt < modulo) begin
        w_step_val = r_cnt + 1'b1;
      end else begin
        w_boundary = 1'b1;
        w_step_val = sat ? modulo : '0;
      end
    end else begin
      // A count left above a lowered modulo snaps back without a boundary
      if (r_cnt > modulo) begin
        w_step_val = modulo;
      end else if (r_cnt == '0) begin
        w_boundary = 1'b1;
        w_step_val = sat ? '0 : modulo;
      end else begin
        w_step_val = r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_pre  <= '0;
      r_tick <= 1'b0;
      r_tc   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_tc   <= 1'b0;
      if (load) begin
        r_cnt <= w_load_val;
        r_pre <= '0;
      end else if (en) begin
        r_pre <= w_step ? '0 : r_pre + 1'b1;
      end
      if (w_step) begin
        r_cnt  <= w_step_val;
        r_tick <= 1'b1;
        r_tc   <= w_boundary;
      end
      // Setting takes precedence over a coincident clear
      if (w_step && w_boundary) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign cnt  = r_cnt;
  assign tick = r_tick;
  assign tc   = r_tc;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_count_mod.sv
// ============================================================================
// Module      : tb_count_mod
// Description : Self-checking bench for count_mod: directed literal checks
//               plus randomized stimulus against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_mod;

  localparam int W  = 3;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0, clr_ovf = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [W-1:0]  modulo = '1;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  cnt;
  logic          tick, tc, ovf;

  int errors = 0;
  int checks = 0;

  // Model state, plain integers
  int m_cnt = 0, m_phase = 0, m_tick = 0, m_tc = 0, m_ovf = 0;

  count_mod #(.COUNTER_WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .modulo(modulo), .prescale(prescale),
    .clr_ovf(clr_ovf), .cnt(cnt), .tick(tick), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: count enabled cycles, step when the count reaches
  // prescale, then move within 0..modulo by the direction/mode rules.
  always @(posedge clk or posedge rst) begin
    int mo, nxt;
    bit bnd, stepped;
    if (rst) begin
      m_cnt = 0; m_phase = 0; m_tick = 0; m_tc = 0; m_ovf = 0;
    end else begin
      mo = int'(modulo);
      stepped = 1'b0;
      bnd = 1'b0;
      nxt = m_cnt;
      if (load) begin
        m_cnt = (int'(load_val) > mo) ? mo : int'(load_val);
        m_phase = 0;
      end else if (en) begin
        if (m_phase == int'(prescale)) begin
          stepped = 1'b1;
          m_phase = 0;
        end else begin
          m_phase = (m_phase + 1) % (1 << PW);
        end
      end
      if (stepped) begin
        if (up) begin
          if (m_cnt < mo) nxt = m_cnt + 1;
          else begin bnd = 1'b1; nxt = sat ? mo : 0; end
        end else begin
          if (m_cnt > mo) nxt = mo;
          else if (m_cnt == 0) begin bnd = 1'b1; nxt = sat ? 0 : mo; end
          else nxt = m_cnt - 1;
        end
        m_cnt = nxt;
      end
      m_tick = stepped ? 1 : 0;
      m_tc   = bnd ? 1 : 0;
      if (bnd) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
  end

  // Single compare process against the model, away from the active edge
  always @(negedge clk) begin
    check("model_cnt", int'(cnt), m_cnt);
    check("model_tick", int'(tick), m_tick);
    check("model_tc", int'(tc), m_tc);
    check("model_ovf", int'(ovf), m_ovf);
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and free-running enable, wrap at modulo 7
    modulo = 3'd7; prescale = '0; up = 1'b1; sat = 1'b0; en = 1'b1;
    clk1(); clk1();
    check("rst_cnt", int'(cnt), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      clk1();
      check("wrap_cnt", int'(cnt), k % 8);
      check("wrap_tc", int'(tc), (k == 8) ? 1 : 0);
      check("wrap_ovf", int'(ovf), (k == 8) ? 1 : 0);
    end

    // Prescale=2 with en gating mid-phase
    load = 1'b1; load_val = '0; modulo = 3'd5; prescale = 2'd2;
    clk1();
    load = 1'b0;
    check("ps_load_cnt", int'(cnt), 0);
    clk1(); check("ps_tick1", int'(tick), 0);
    clk1(); check("ps_tick2", int'(tick), 0);
    clk1(); check("ps_step_tick", int'(tick), 1); check("ps_step_cnt", int'(cnt), 1);
    clk1(); check("ps_pulse_end", int'(tick), 0);
    en = 1'b0;
    clk1(); clk1();
    check("ps_hold_cnt", int'(cnt), 1);
    en = 1'b1;
    clk1(); check("ps_resume_tick", int'(tick), 0);
    clk1(); check("ps_resume_step", int'(tick), 1); check("ps_resume_cnt", int'(cnt), 2);

    // Down count with wrap at modulo 5
    prescale = '0; up = 1'b0; sat = 1'b0; load = 1'b1; load_val = 3'd1;
    clk1(); load = 1'b0;
    check("dn_load", int'(cnt), 1);
    clk1(); check("dn_cnt0", int'(cnt), 0); check("dn_tc0", int'(tc), 0);
    clk1(); check("dn_cnt5", int'(cnt), 5); check("dn_tc5", int'(tc), 1);
    clk1(); check("dn_cnt4", int'(cnt), 4); check("dn_tc4", int'(tc), 0);

    // Saturate up then down
    sat = 1'b1; up = 1'b1; load = 1'b1; load_val = 3'd4;
    clk1(); load = 1'b0;
    clk1(); check("sat_up5", int'(cnt), 5); check("sat_up_tc0", int'(tc), 0);
    clk1(); check("sat_hold5a", int'(cnt), 5); check("sat_tc_a", int'(tc), 1);
    clk1(); check("sat_hold5b", int'(cnt), 5); check("sat_tc_b", int'(tc), 1);
    up = 1'b0;
    repeat (5) clk1();
    check("sat_dn0", int'(cnt), 0); check("sat_dn_tc", int'(tc), 0);
    clk1(); check("sat_hold0", int'(cnt), 0); check("sat_hold0_tc", int'(tc), 1);

    // Load priority with clamp, then modulo lowered below count
    prescale = 2'd2; load = 1'b1; load_val = 3'd6; modulo = 3'd5; en = 1'b1;
    clk1(); load = 1'b0;
    check("ld_clamp", int'(cnt), 5); check("ld_tick", int'(tick), 0);
    modulo = 3'd2; up = 1'b0; sat = 1'b0;
    clk1(); check("ld_pre1", int'(tick), 0);
    clk1(); check("ld_pre2", int'(tick), 0);
    clk1(); check("low_mod_cnt", int'(cnt), 2); check("low_mod_tc", int'(tc), 0);
    check("low_mod_tick", int'(tick), 1);

    // Sticky ovf, clear, and set-wins-over-clear
    prescale = '0; up = 1'b1;
    clk1(); check("ovf_wrap_cnt", int'(cnt), 0); check("ovf_set", int'(ovf), 1);
    en = 1'b0;
    repeat (3) clk1();
    check("ovf_sticky", int'(ovf), 1);
    clr_ovf = 1'b1;
    clk1(); check("ovf_clr", int'(ovf), 0);
    en = 1'b1;
    clk1(); clk1();
    check("ovf_clr_steps", int'(ovf), 0);
    clk1(); check("ovf_setwins", int'(ovf), 1); check("ovf_setwins_tc", int'(tc), 1);
    clr_ovf = 1'b0;

    // Randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(3) != 0);
      up       = $urandom_range(1);
      sat      = ($urandom_range(4) == 0);
      load     = ($urandom_range(9) == 0);
      load_val = W'($urandom);
      clr_ovf  = ($urandom_range(9) == 0);
      if ($urandom_range(15) == 0) modulo = W'($urandom);
      if ($urandom_range(31) == 0) prescale = PW'($urandom);
      clk1();
    end

    // Asynchronous reset mid-count
    load = 1'b0; en = 1'b1; prescale = '0; modulo = 3'd4; up = 1'b1; sat = 1'b0;
    repeat (7) clk1();
    #2 rst = 1'b1;
    #1;
    check("arst_cnt", int'(cnt), 0);
    check("arst_tick", int'(tick), 0);
    check("arst_tc", int'(tc), 0);
    check("arst_ovf", int'(ovf), 0);
    clk1();
    rst = 1'b0;
    clk1();
    check("arst_restart", int'(cnt), 1);
    clk1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
